// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared layer register constants, field positions and commit FSM states
package gpu_pkg;

  localparam int LAYER_BITS  = 128;
  localparam int WORD_BITS   = 16;
  localparam int LAYER_WORDS = LAYER_BITS / WORD_BITS;

  // Field positions inside one layer register set
  localparam int IS_POPULATED_BIT = 0;
  localparam int IS_SPRITE_BIT    = 1;
  localparam int WIDTH_LSB        = 16;
  localparam int WIDTH_W          = 5;
  localparam int HEIGHT_LSB       = 32;
  localparam int HEIGHT_W         = 5;
  localparam int XPOS_LSB         = 48;
  localparam int XPOS_W           = 5;
  localparam int YPOS_LSB         = 64;
  localparam int YPOS_W           = 5;
  localparam int NUM_CHARS_LSB    = 96;
  localparam int NUM_CHARS_W      = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } commit_state_t;

endpackage

// File: rtl/layer_commit_sequencer.sv
// rtl/layer_commit_sequencer.sv - vblank commit FSM: scan index, commit_done pulse, sticky overrun
module layer_commit_sequencer
  import gpu_pkg::*;
#(
  parameter int NUM_LAYERS = 16,
  parameter int IDX_W      = $clog2(NUM_LAYERS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_sync,
  input  logic             dirty_any,
  output logic             wr_ready,
  output logic             commit_en,
  output logic [IDX_W-1:0] commit_idx,
  output logic             commit_done,
  output logic             overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);

  commit_state_t state;

  assign commit_en = (state == ST_COMMIT);

  // Walk every layer once per commit; frame_sync while busy only flags overrun
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      commit_idx  <= '0;
      wr_ready    <= 1'b0;
      commit_done <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      commit_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          wr_ready <= 1'b1;
          if (frame_sync && dirty_any) begin
            state      <= ST_COMMIT;
            commit_idx <= '0;
            wr_ready   <= 1'b0;
          end
        end
        ST_COMMIT: begin
          if (frame_sync) begin
            overrun <= 1'b1;
          end
          if (commit_idx == LAST_IDX) begin
            state       <= ST_IDLE;
            commit_idx  <= '0;
            wr_ready    <= 1'b1;
            commit_done <= 1'b1;
          end else begin
            commit_idx <= commit_idx + IDX_W'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          wr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/layer_register_loader.sv
// rtl/layer_register_loader.sv - double-buffered layer registers committed at vblank (optional LAYER_READBACK_EN)
module layer_register_loader
  import gpu_pkg::*;
#(
  parameter int NUM_LAYERS = 16,
  parameter int LAYER_BITS = gpu_pkg::LAYER_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [3:0]            wr_layer,
  input  logic [2:0]            wr_word,
  input  logic [15:0]           wr_data,
  input  logic                  frame_sync,
  input  logic [3:0]            rd_layer,
`ifdef LAYER_READBACK_EN
  input  logic [3:0]            rb_layer,
  input  logic [2:0]            rb_word,
  output logic [15:0]           rb_data,
`endif
  output logic [LAYER_BITS-1:0] layerRegisters,
  output logic                  pending,
  output logic                  commit_done,
  output logic                  overrun
);

  localparam int IDX_W = $clog2(NUM_LAYERS);
  localparam int WORDS = LAYER_BITS / WORD_BITS;

  logic [LAYER_BITS-1:0] shadow [NUM_LAYERS];
  logic [LAYER_BITS-1:0] active [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] dirty;

  logic             wr_in_range;
  logic             rd_in_range;
  logic             wr_accept;
  logic             dirty_any;
  logic             commit_en;
  logic [IDX_W-1:0] commit_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_in_range = ({1'b0, wr_layer} < 5'(NUM_LAYERS));
  assign rd_in_range = ({1'b0, rd_layer} < 5'(NUM_LAYERS));
  assign wr_idx      = wr_layer[IDX_W-1:0];
  assign rd_idx      = rd_layer[IDX_W-1:0];
  assign wr_accept   = wr_valid && wr_ready && wr_in_range;
  // A write landing on the frame_sync cycle must still trigger that commit
  assign dirty_any   = (|dirty) || wr_accept;

  layer_commit_sequencer #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W)
  ) u_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_sync  (frame_sync),
    .dirty_any   (dirty_any),
    .wr_ready    (wr_ready),
    .commit_en   (commit_en),
    .commit_idx  (commit_idx),
    .commit_done (commit_done),
    .overrun     (overrun)
  );

  // Host writes fill shadow; commit scan moves dirty shadow sets into active
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int l = 0; l < NUM_LAYERS; l++) begin
        shadow[l] <= '0;
        active[l] <= '0;
      end
      dirty <= '0;
    end else begin
      if (wr_accept) begin
        for (int w = 0; w < WORDS; w++) begin
          if (wr_word == 3'(w)) begin
            shadow[wr_idx][w*WORD_BITS +: WORD_BITS] <= wr_data;
          end
        end
        dirty[wr_idx] <= 1'b1;
      end
      if (commit_en) begin
        if (dirty[commit_idx]) begin
          active[commit_idx] <= shadow[commit_idx];
        end
        dirty[commit_idx] <= 1'b0;
      end
    end
  end

  // Registered renderer read port and pending flag; reads see pre-copy data on the copy cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      layerRegisters <= '0;
      pending        <= 1'b0;
    end else begin
      layerRegisters <= rd_in_range ? active[rd_idx] : '0;
      pending        <= |dirty;
    end
  end

`ifdef LAYER_READBACK_EN
  logic                  rb_in_range;
  logic [LAYER_BITS-1:0] rb_set;
  logic [15:0]           rb_word_sel;

  assign rb_in_range = ({1'b0, rb_layer} < 5'(NUM_LAYERS));
  assign rb_set      = shadow[rb_layer[IDX_W-1:0]];

  // Select the requested 16-bit word out of the shadow set
  always_comb begin
    rb_word_sel = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (rb_word == 3'(w)) begin
        rb_word_sel = rb_set[w*WORD_BITS +: WORD_BITS];
      end
    end
  end

  // Registered host readback of shadow contents
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rb_data <= '0;
    end else begin
      rb_data <= rb_in_range ? rb_word_sel : '0;
    end
  end
`endif

endmodule
